alu_rr_scheduler: RTL

//  Shares one combinational alu (16-bit barrel rotate + set-less-than) between NREQ requesters.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_rr_scheduler_arbiter.sv | 28 ++
 rtl/alu_rr_scheduler.sv | 72 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared alu widths, opcode field indices and scheduler state encoding
package alu_pkg;
  localparam int ALU_W = 16;
  localparam int ALU_OPW = 6;
  localparam int OP_SLT = 0;
  localparam int OP_DIR = 1;
  localparam int OP_AMT8 = 2;
  localparam int OP_AMT4 = 3;
  localparam int OP_AMT2 = 4;
  localparam int OP_AMT1 = 5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  typedef logic [ALU_W-1:0] word_t;
  typedef logic [ALU_OPW-1:0] opcode_t;
  // Opcode fields are numbered from the MSB: field 0 is op[ALU_OPW-1].
  function automatic logic op_bit(input opcode_t op, input int f);
    return op[ALU_OPW-1-f];
  endfunction
endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      if (!any && req[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one alu among NREQ requesters, one op in flight
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int WIDTH = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [WIDTH-1:0]      alu_inp0,
  output logic [WIDTH-1:0]      alu_inp1,
  output logic [OPW-1:0]        alu_opcode,
  input  logic [WIDTH-1:0]      alu_opt,
  output logic                  busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [1:0] state;
  logic [PW-1:0] rr_ptr, owner, grant;
  logic [NREQ-1:0] gnt;
  logic any;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(grant),
    .any(any)
  );
  always_comb begin
    req_ready = (state == S_IDLE) ? gnt : '0;
    rsp_valid = (state == S_RESP) ? (NREQ'(1) << owner) : '0;
    busy = state != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      owner <= '0;
      rsp_data <= '0;
      alu_inp0 <= '0;
      alu_inp1 <= '0;
      alu_opcode <= '0;
    end else begin
      case (state)
        S_IDLE: if (any) begin
          alu_inp0 <= req_a[grant*WIDTH +: WIDTH];
          alu_inp1 <= req_b[grant*WIDTH +: WIDTH];
          alu_opcode <= req_op[grant*OPW +: OPW];
          owner <= grant;
          state <= S_EXEC;
        end
        S_EXEC: begin
          rsp_data <= alu_opt;
          state <= S_RESP;
        end
        S_RESP: if (rsp_ready[owner]) begin
          rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
